// File: rtl/fp16_extrapolator.sv
// FP16 forward extrapolator over a backward-difference table, one truncating add per cycle.
// float_adder aligns both operands exactly in fixed point, then truncates toward zero.

module float_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        overflow,
  output logic        nan,
  output logic        precisionLost
);
  logic [10:0]        ma, mb;
  logic [4:0]         sha, shb, sh, ex;
  logic [40:0]        fa, fb, mag, lost_mask;
  logic [9:0]         norm;
  logic signed [41:0] va, vb, vs;
  logic [5:0]         p;
  logic               sgn, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    a_inf = (a[14:10] == 5'h1f) && (a[9:0] == '0);
    b_inf = (b[14:10] == 5'h1f) && (b[9:0] == '0);
    a_nan = (a[14:10] == 5'h1f) && (a[9:0] != '0);
    b_nan = (b[14:10] == 5'h1f) && (b[9:0] != '0);
    ma  = {(a[14:10] != '0), a[9:0]};
    mb  = {(b[14:10] != '0), b[9:0]};
    sha = (a[14:10] == '0) ? '0 : a[14:10] - 5'd1;
    shb = (b[14:10] == '0) ? '0 : b[14:10] - 5'd1;
    // Both operands as integers in units of 2^-24: the sum is exact before truncation.
    fa  = {30'd0, ma} << sha;
    fb  = {30'd0, mb} << shb;
    va  = a[15] ? -$signed({1'b0, fa}) : $signed({1'b0, fa});
    vb  = b[15] ? -$signed({1'b0, fb}) : $signed({1'b0, fb});
    vs  = va + vb;
    mag = vs[41] ? 41'(-vs) : vs[40:0];
    sgn = (mag == '0) ? (a[15] & b[15]) : vs[41];
    p = '0;
    for (int unsigned i = 0; i < 41; i++)
      if (mag[i]) p = 6'(i);
    sh = '0;
    ex = '0;
    norm = '0;
    lost_mask = '0;
    sum = '0;
    overflow = 1'b0;
    nan = 1'b0;
    precisionLost = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      sum = 16'h7e00;
      nan = 1'b1;
    end else if (a_inf) begin
      sum = a;
    end else if (b_inf) begin
      sum = b;
    end else if (mag < 41'd1024) begin
      sum = {sgn, 5'd0, mag[9:0]};
    end else if (p >= 6'd40) begin
      sum = {sgn, 15'h7c00};
      overflow = 1'b1;
    end else begin
      sh = 5'(p - 6'd10);
      ex = 5'(p - 6'd9);
      norm = 10'(mag >> sh);
      lost_mask = (41'd1 << sh) - 41'd1;
      precisionLost = |(mag & lost_mask);
      sum = {sgn, ex, norm};
    end
  end
endmodule

module fp16_extrapolator #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [WORD_SIZE-1:0] ld_data,
  input  logic                 start,
  input  logic [7:0]           num_terms,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 done,
  output logic                 ovf_sticky,
  output logic                 nan_sticky,
  output logic                 plost_sticky
);
  typedef enum logic [1:0] {LOAD, ARMED, CALC, EMIT} state_t;
  localparam logic [3:0] LAST = 4'(DEPTH - 1);

  state_t               state;
  logic [WORD_SIZE-1:0] d [DEPTH];
  logic [3:0]           idx, k;
  logic [7:0]           rem;
  logic [WORD_SIZE-1:0] add_a, add_b, add_sum;
  logic                 add_ovf, add_nan, add_plost;

  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 1; i < DEPTH; i++)
      if (k == 4'(i)) begin
        add_a = d[i];
        add_b = d[i-1];
      end
  end

  float_adder u_add (
    .a(add_a), .b(add_b), .sum(add_sum),
    .overflow(add_ovf), .nan(add_nan), .precisionLost(add_plost)
  );

  assign ld_ready  = (state == LOAD) || ((state == ARMED) && !start);
  assign busy      = (state == CALC) || (state == EMIT);
  assign out_valid = (state == EMIT);
  assign out_data  = d[DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      idx <= '0;
      k <= '0;
      rem <= '0;
      done <= 1'b0;
      ovf_sticky <= 1'b0;
      nan_sticky <= 1'b0;
      plost_sticky <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) d[i] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        LOAD: if (ld_valid) begin
          for (int unsigned i = 0; i < DEPTH; i++)
            if (idx == 4'(i)) d[i] <= ld_data;
          if (idx == LAST) begin
            idx <= '0;
            state <= ARMED;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ARMED: if (start) begin
          ovf_sticky <= 1'b0;
          nan_sticky <= 1'b0;
          plost_sticky <= 1'b0;
          if (num_terms == '0) begin
            done <= 1'b1;
          end else begin
            rem <= num_terms;
            k <= 4'd1;
            state <= CALC;
          end
        end else if (ld_valid) begin
          d[0] <= ld_data;
          idx <= 4'd1;
          state <= LOAD;
        end
        CALC: begin
          for (int unsigned i = 1; i < DEPTH; i++)
            if (k == 4'(i)) d[i] <= add_sum;
          ovf_sticky <= ovf_sticky | add_ovf;
          nan_sticky <= nan_sticky | add_nan;
          plost_sticky <= plost_sticky | add_plost;
          if (k == LAST) state <= EMIT;
          else k <= k + 4'd1;
        end
        EMIT: if (out_ready) begin
          rem <= rem - 8'd1;
          if (rem == 8'd1) begin
            done <= 1'b1;
            state <= ARMED;
          end else begin
            k <= 4'd1;
            state <= CALC;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: doc/fp16_extrapolator.md
# fp16_extrapolator

Downstream consumer of the FP16 backward-difference engine. It takes the finished difference table, one entry per beat, ordered highest-order difference first. The last entry is the newest sample. It then extrapolates the sequence forward by up to 255 terms, using one FP16 add per cycle through the existing `float_adder`. Each predicted term leaves on a valid/ready output port. Sticky overflow, NaN and precision-lost flags are kept.

## Interface
- `WORD_SIZE`, 16, FP16 word width; fixed at 16.
- `DEPTH`, 6, number of table entries (difference engine `N_1`+1); legal range 2..15.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `ld_valid`  in  1  table entry present on `ld_data`.
- `ld_ready`  out  1  block accepts a table entry.
- `ld_data`  in  16  FP16 table entry; beat i writes `d[i]`.
- `start`  in  1  single-cycle request to extrapolate `num_terms` terms.
- `num_terms`  in  8  term count, sampled when `start` is accepted.
- `busy`  out  1  high in CALC and EMIT.
- `out_valid`  out  1  predicted term on `out_data`.
- `out_ready`  in  1  consumer takes the term.
- `out_data`  out  16  predicted FP16 term (`d[DEPTH-1]`).
- `done`  out  1  one-cycle pulse when a start request completes.
- `ovf_sticky`, `nan_sticky`, `plost_sticky`  out  1 each  ORed adder flags since the last accepted `start`.

## Operation
- Storage: `d[0..DEPTH-1]`, 16 bits each.
  - `d[0]` is the highest-order difference and stays constant.
  - `d[DEPTH-1]` is the newest sample.
- States: LOAD, ARMED, CALC, EMIT. Reset enters LOAD with `idx`=0.
- LOAD
  - `ld_ready`=1.
  - Each beat (`ld_valid`&`ld_ready`) writes `d[idx]` and increments `idx`.
  - The beat with `idx`=DEPTH-1 moves to ARMED.
  - `start` is ignored in LOAD.
- ARMED
  - `ld_ready`=!`start`.
  - A load beat writes `d[0]`, sets `idx`=1 and moves to LOAD. This is a fresh table.
  - `start` with `num_terms`=0: `done` pulses next cycle and the state stays ARMED. Sticky flags are still cleared.
  - `start` with `num_terms`≠0: latch `rem`=`num_terms`, clear sticky flags, set `k`=1, go to CALC.
  - `start` has priority over `ld_valid` in the same cycle.
- CALC, one add per cycle
  - `d[k]` <= `float_adder(d[k], d[k-1])`, using the already-updated `d[k-1]`.
  - OR the adder's overflow, NaN and precisionLost outputs into the stickies.
  - When `k`=DEPTH-1, go to EMIT; otherwise `k`++.
- EMIT
  - `out_valid`=1 and `out_data`=`d[DEPTH-1]`, held stable until `out_ready`.
  - On transfer, `rem`--.
  - If `rem` becomes 0: go to ARMED and pulse `done` in the next cycle.
  - Otherwise set `k`=1 and return to CALC.
- The table persists after a run. A later `start` from ARMED continues extrapolating from the current state.
- All arithmetic goes through `float_adder`, which truncates and does not round. No other FP logic lives in this block.
- `ld_ready`, `out_valid`, `busy` and `done` are registered-state decodes with no combinational path from `out_ready` or `ld_valid`. The one exception is the `start` gating of `ld_ready` in ARMED.

## Timing
- Reset values:
  - state LOAD, `idx`=0, `k`=0, `rem`=0, all `d[i]`=0.
  - `ld_ready`=1 after reset, because the state is LOAD.
  - `busy`, `out_valid`, `done`, all stickies = 0; `out_data`=0.
- `rst_n` low in any state, including mid-CALC or mid-EMIT, aborts on the next edge.
  - A pending output is dropped.
  - `done` is not pulsed.
- Load: DEPTH accepted beats. With `ld_valid` held high, ARMED is reached DEPTH cycles after the first beat.
- Start accepted at edge T:
  - CALC occupies edges T+1..T+DEPTH-1.
  - `out_valid` is high from T+DEPTH.
- With `out_ready` held high, throughput is one term per DEPTH cycles.
- `done` is high for exactly one cycle, the cycle after the final output transfer. `busy` is low in that cycle.
- `out_ready` high outside EMIT has no effect. Backpressure of any length stalls only EMIT; the table stays unchanged.

## Test plan
- Squares, num_terms=3: load 0000,0000,0000,4000,4880,4E40 (0,0,0,2,9,25), start.
  - Outputs 5080, 5220, 5400 (36, 49, 64).
  - `done` pulses once; all stickies are 0.
- Continuation: after the squares run, start with num_terms=1 -> output 5510 (81).
- Backpressure: hold `out_ready` low for 10 cycles in EMIT.
  - `out_data` holds 5080; `out_valid` stays high; `busy`=1.
  - After release the next term arrives exactly DEPTH cycles after the transfer.
- Overflow: load d[DEPTH-1]=7BFF, d[DEPTH-2]=7BFF, others 0, num_terms=1.
  - Output 7C00 (inf); `ovf_sticky`=1.
  - The next start clears the flag.
- Reset mid-run: assert `rst_n`=0 during CALC.
  - Next cycle: state LOAD, `ld_ready`=1, `out_valid`=0, table is zero.
  - No `done` pulse.
- Corner cases:
  - `start`, or `start` with num_terms=0, while in LOAD -> ignored.
  - num_terms=0 in ARMED -> `done` one cycle later, no output beat.
  - `start` and `ld_valid` together in ARMED -> start wins and the load beat is not consumed.
